// File: rtl/prio_encoder_queue.sv
// Registered N-to-W priority encoder. Request pulses collect in a pending register,
// and their binary codes are issued one per transfer over a valid/ready output.
module prio_encoder_queue #(
   parameter int N    = 8,
   parameter int W    = 3,
   parameter int MODE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [W-1:0] out_code,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] pending,
   output logic         overflow
);

   if (N < 2 || N > 64) begin : g_bad_n
      $error("prio_encoder_queue: N must be in 2..64");
   end
   if ((64'd1 << W) < 64'(N)) begin : g_bad_w
      $error("prio_encoder_queue: 2**W must be >= N");
   end
   if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("prio_encoder_queue: MODE must be 0 or 1");
   end

   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] out_code_q, out_code_d;
   logic         out_valid_q, out_valid_d;
   logic         overflow_q, overflow_d;
   logic [W-1:0] ptr_q, ptr_d;

   logic         load;
   logic [N-1:0] load_mask;
   logic [W-1:0] sel_code;
   logic [N-1:0] rot;
   logic         found;
   logic [W:0]   sum;
   logic [W:0]   ptr_inc;

   assign load = !out_valid_q || out_ready;

   // Winner search looks only at the registered pending set, never at req.
   always_comb begin
      sel_code = '0;
      found    = 1'b0;
      sum      = '0;
      rot      = N'({pending_q, pending_q} >> ptr_q);
      if (MODE == 0) begin
         for (int i = 0; i < N; i++) begin
            if (pending_q[i]) sel_code = W'(i);
         end
      end else begin
         for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
               found = 1'b1;
               sum   = {1'b0, ptr_q} + (W+1)'(j);
               if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
               sel_code = sum[W-1:0];
            end
         end
      end
   end

   always_comb begin
      load_mask   = '0;
      out_code_d  = out_code_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      ptr_inc     = {1'b0, sel_code} + (W+1)'(1);
      if (load) begin
         if (|pending_q) begin
            out_code_d  = sel_code;
            out_valid_d = 1'b1;
            load_mask   = N'(1) << sel_code;
            if (MODE == 1) ptr_d = (ptr_inc == (W+1)'(N)) ? '0 : ptr_inc[W-1:0];
         end else begin
            out_valid_d = 1'b0;
         end
      end
      // A repeat on the bit being loaded this cycle re-arms it rather than overflowing.
      pending_d  = (pending_q & ~load_mask) | req;
      overflow_d = |(req & pending_q & ~load_mask);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         out_code_q  <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         ptr_q       <= '0;
      end else begin
         pending_q   <= pending_d;
         out_code_q  <= out_code_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_code  = out_code_q;
   assign out_valid = out_valid_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_prio_encoder_queue.sv
// Directed bench: a fixed-priority and a round-robin instance on one clock,
// each step compared against hand-computed values.
module tb_prio_encoder_queue;

   logic       clk = 1'b0;
   logic       f_rst, f_ready, f_valid, f_ovf;
   logic [7:0] f_req, f_pend;
   logic [2:0] f_code;
   logic       r_rst, r_ready, r_valid, r_ovf;
   logic [7:0] r_req, r_pend;
   logic [2:0] r_code;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   prio_encoder_queue #(.N(8), .W(3), .MODE(0)) u_fix (
      .clk(clk), .rst(f_rst), .req(f_req), .out_code(f_code), .out_valid(f_valid),
      .out_ready(f_ready), .pending(f_pend), .overflow(f_ovf)
   );

   prio_encoder_queue #(.N(8), .W(3), .MODE(1)) u_rr (
      .clk(clk), .rst(r_rst), .req(r_req), .out_code(r_code), .out_valid(r_valid),
      .out_ready(r_ready), .pending(r_pend), .overflow(r_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_f(input string tag, input logic [7:0] pend, input logic v,
                          input logic [2:0] code, input logic ovf);
      check({tag, ".pending"}, 32'(f_pend), 32'(pend));
      check({tag, ".valid"}, 32'(f_valid), 32'(v));
      if (v) check({tag, ".code"}, 32'(f_code), 32'(code));
      check({tag, ".overflow"}, 32'(f_ovf), 32'(ovf));
   endtask

   task automatic check_r(input string tag, input logic [7:0] pend, input logic v,
                          input logic [2:0] code, input logic ovf);
      check({tag, ".pending"}, 32'(r_pend), 32'(pend));
      check({tag, ".valid"}, 32'(r_valid), 32'(v));
      if (v) check({tag, ".code"}, 32'(r_code), 32'(code));
      check({tag, ".overflow"}, 32'(r_ovf), 32'(ovf));
   endtask

   initial begin
      f_rst = 1'b1; f_req = 8'hFF; f_ready = 1'b1;
      r_rst = 1'b1; r_req = 8'hFF; r_ready = 1'b1;

      // Reset with all requests high: nothing may be captured.
      tick(); check_f("rst1_f", 8'h00, 1'b0, 3'd0, 1'b0); check_r("rst1_r", 8'h00, 1'b0, 3'd0, 1'b0);
      check("rst1_f.code", 32'(f_code), 32'd0);
      tick(); check_f("rst2_f", 8'h00, 1'b0, 3'd0, 1'b0); check_r("rst2_r", 8'h00, 1'b0, 3'd0, 1'b0);
      f_rst = 1'b0; f_req = 8'h00; r_rst = 1'b0; r_req = 8'h00;
      tick(); check_f("idle_f", 8'h00, 1'b0, 3'd0, 1'b0); check_r("idle_r", 8'h00, 1'b0, 3'd0, 1'b0);

      // Fixed priority: highest index first, 2-cycle latency.
      f_req = 8'b1010_0100;
      tick(); check_f("fp_cap", 8'hA4, 1'b0, 3'd0, 1'b0);
      f_req = 8'h00;
      tick(); check_f("fp_7", 8'h24, 1'b1, 3'd7, 1'b0);
      tick(); check_f("fp_5", 8'h04, 1'b1, 3'd5, 1'b0);
      tick(); check_f("fp_2", 8'h00, 1'b1, 3'd2, 1'b0);
      tick(); check_f("fp_idle", 8'h00, 1'b0, 3'd0, 1'b0);

      // Round-robin with every request held high.
      r_req = 8'hFF;
      tick(); check_r("rr_cap", 8'hFF, 1'b0, 3'd0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick(); check_r($sformatf("rr_seq%0d", i), 8'hFF, 1'b1, 3'(i % 8), 1'b1);
      end
      r_req = 8'h02;
      tick(); check_r("rr_same1", 8'hFF, 1'b1, 3'd1, 1'b0);
      r_req = 8'h04;
      tick(); check_r("rr_same2", 8'hFF, 1'b1, 3'd2, 1'b0);
      r_req = 8'h01;
      tick(); check_r("rr_dup0", 8'hF7, 1'b1, 3'd3, 1'b1);
      r_req = 8'h00;
      begin
         logic [2:0] exp_code [7] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
         logic [7:0] exp_pend [7] = '{8'hE7, 8'hC7, 8'h87, 8'h07, 8'h06, 8'h04, 8'h00};
         for (int i = 0; i < 7; i++) begin
            tick(); check_r($sformatf("rr_drain%0d", i), exp_pend[i], 1'b1, exp_code[i], 1'b0);
         end
      end
      tick(); check_r("rr_empty", 8'h00, 1'b0, 3'd0, 1'b0);

      // Backpressure: held code stays stable while pending accumulates.
      f_ready = 1'b0; f_req = 8'h01;
      tick(); check_f("bp_cap", 8'h01, 1'b0, 3'd0, 1'b0);
      f_req = 8'h80;
      tick(); check_f("bp_issue0", 8'h80, 1'b1, 3'd0, 1'b0);
      f_req = 8'h00;
      tick(); check_f("bp_hold1", 8'h80, 1'b1, 3'd0, 1'b0);
      tick(); check_f("bp_hold2", 8'h80, 1'b1, 3'd0, 1'b0);
      f_ready = 1'b1;
      tick(); check_f("bp_issue7", 8'h00, 1'b1, 3'd7, 1'b0);
      tick(); check_f("bp_idle", 8'h00, 1'b0, 3'd0, 1'b0);

      // Request on the bit being loaded: no overflow, reissued.
      f_req = 8'h08;
      tick(); check_f("sc_cap", 8'h08, 1'b0, 3'd0, 1'b0);
      tick(); check_f("sc_load", 8'h08, 1'b1, 3'd3, 1'b0);
      f_req = 8'h00;
      tick(); check_f("sc_again", 8'h00, 1'b1, 3'd3, 1'b0);
      // Request on a bit that is merely pending: one-cycle overflow.
      f_ready = 1'b0; f_req = 8'h08;
      tick(); check_f("ov_cap", 8'h08, 1'b1, 3'd3, 1'b0);
      tick(); check_f("ov_hit", 8'h08, 1'b1, 3'd3, 1'b1);
      f_req = 8'h00;
      tick(); check_f("ov_clear", 8'h08, 1'b1, 3'd3, 1'b0);
      f_ready = 1'b1;
      tick(); check_f("ov_drain", 8'h00, 1'b1, 3'd3, 1'b0);
      tick(); check_f("ov_idle", 8'h00, 1'b0, 3'd0, 1'b0);

      // Mid-operation reset drops the held code and the pending set.
      f_ready = 1'b0; f_req = 8'h10;
      tick(); check_f("mr_cap", 8'h10, 1'b0, 3'd0, 1'b0);
      f_req = 8'h0F;
      tick(); check_f("mr_full", 8'h0F, 1'b1, 3'd4, 1'b0);
      f_req = 8'h00; f_rst = 1'b1;
      tick(); check_f("mr_rst", 8'h00, 1'b0, 3'd0, 1'b0);
      check("mr_rst.code", 32'(f_code), 32'd0);
      f_rst = 1'b0; f_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); check_f($sformatf("mr_after%0d", i), 8'h00, 1'b0, 3'd0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
